// File: rtl/drum_transfer_unit.sv
// Drum transfer unit: moves one tube page between main store and a drum track,
// issuing a store scan beat after every word so beam rotation keeps advancing.
module drum_transfer_unit #(
  parameter int LINE_LENGTH     = 40,
  parameter int INSTR_ADDR_BITS = 10,
  parameter int TUBE_DEPTH      = 32,
  parameter int N_TUBES         = 2,
  parameter int TRACK_BITS      = 8
) (
  input  logic                       w_CLK,
  input  logic                       w_RST,
  input  logic                       w_START,
  input  logic                       w_DIR,
  input  logic [4:0]                 b_TUBE_SEL,
  input  logic [TRACK_BITS-1:0]      b_TRACK_SEL,
  input  logic                       w_BUS_GNT,
  output logic                       w_BUS_REQ,
  output logic                       ready_out,
  output logic                       ready_in,
  output logic                       w_HS,
  output logic [INSTR_ADDR_BITS-1:0] b_MS_ADDR,
  output logic [LINE_LENGTH-1:0]     b_MS_ZERO,
  output logic [LINE_LENGTH-1:0]     b_MS_DATA_IN,
  input  logic [LINE_LENGTH-1:0]     b_MS_DATA_OUT,
  output logic [TRACK_BITS-1:0]      b_DRUM_TRACK,
  output logic [LINE_LENGTH-1:0]     b_DRUM_WDATA,
  output logic                       w_DRUM_WVALID,
  input  logic                       w_DRUM_WREADY,
  input  logic [LINE_LENGTH-1:0]     b_DRUM_RDATA,
  input  logic                       w_DRUM_RVALID,
  output logic                       w_DRUM_RREADY,
  output logic                       w_BUSY,
  output logic                       w_DONE
);

  localparam int WORD_BITS = INSTR_ADDR_BITS - 5;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(TUBE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_BEAT,
    S_RD_CAPT,
    S_DRUM_PUSH,
    S_WR_WAIT,
    S_WR_BEAT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic                    dir_reg, dir_next;
  logic [4:0]              tube_reg, tube_next;
  logic [TRACK_BITS-1:0]   track_reg, track_next;
  logic [WORD_BITS-1:0]    count_reg, count_next;
  logic [LINE_LENGTH-1:0]  buf_reg, buf_next;
  logic                    zero_all;
  logic [INSTR_ADDR_BITS-1:0] page_addr;

  always_ff @(posedge w_CLK) begin
    if (w_RST) begin
      state_reg <= S_IDLE;
      dir_reg   <= 1'b0;
      tube_reg  <= '0;
      track_reg <= '0;
      count_reg <= '0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      tube_reg  <= tube_next;
      track_reg <= track_next;
      count_reg <= count_next;
      buf_reg   <= buf_next;
    end
  end

  assign page_addr    = {tube_reg, count_reg};
  assign b_DRUM_TRACK = track_reg;
  assign w_BUSY       = (state_reg != S_IDLE) && (state_reg != S_DONE);

  // Write beats replace the whole line, so the zero mask is all-or-nothing.
  generate
    for (genvar gi = 0; gi < LINE_LENGTH; gi++) begin : g_zero
      assign b_MS_ZERO[gi] = zero_all;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    dir_next      = dir_reg;
    tube_next     = tube_reg;
    track_next    = track_reg;
    count_next    = count_reg;
    buf_next      = buf_reg;
    w_BUS_REQ     = 1'b0;
    ready_out     = 1'b0;
    ready_in      = 1'b0;
    w_HS          = 1'b0;
    b_MS_ADDR     = '0;
    zero_all      = 1'b0;
    b_MS_DATA_IN  = '0;
    b_DRUM_WDATA  = '0;
    w_DRUM_WVALID = 1'b0;
    w_DRUM_RREADY = 1'b0;
    w_DONE        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (w_START) begin
          dir_next   = w_DIR;
          tube_next  = b_TUBE_SEL;
          track_next = b_TRACK_SEL;
          count_next = '0;
          if ({1'b0, b_TUBE_SEL} >= 6'(N_TUBES)) begin
            state_next = S_DONE;
          end else begin
            state_next = w_DIR ? S_RD_BEAT : S_WR_WAIT;
          end
        end
      end

      S_RD_BEAT: begin
        w_BUS_REQ = 1'b1;
        if (w_BUS_GNT) begin
          ready_out  = 1'b1;
          b_MS_ADDR  = page_addr;
          state_next = S_RD_CAPT;
        end
      end

      // Store read data arrives one cycle after the read beat.
      S_RD_CAPT: begin
        buf_next   = b_MS_DATA_OUT;
        state_next = S_DRUM_PUSH;
      end

      S_DRUM_PUSH: begin
        w_DRUM_WVALID = 1'b1;
        b_DRUM_WDATA  = buf_reg;
        if (w_DRUM_WREADY) begin
          state_next = S_SCAN;
        end
      end

      S_WR_WAIT: begin
        w_DRUM_RREADY = 1'b1;
        if (w_DRUM_RVALID) begin
          buf_next   = b_DRUM_RDATA;
          state_next = S_WR_BEAT;
        end
      end

      S_WR_BEAT: begin
        w_BUS_REQ = 1'b1;
        if (w_BUS_GNT) begin
          ready_in     = 1'b1;
          b_MS_ADDR    = page_addr;
          zero_all     = 1'b1;
          b_MS_DATA_IN = buf_reg;
          state_next   = S_SCAN;
        end
      end

      S_SCAN: begin
        w_BUS_REQ = 1'b1;
        if (w_BUS_GNT) begin
          ready_in = 1'b1;
          w_HS     = 1'b1;
          if (count_reg == LAST_WORD) begin
            count_next = '0;
            state_next = S_DONE;
          end else begin
            count_next = count_reg + 1'b1;
            state_next = dir_reg ? S_RD_BEAT : S_WR_WAIT;
          end
        end
      end

      S_DONE: begin
        w_DONE     = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_drum_transfer_unit.sv
// Bench for drum_transfer_unit: store and drum responders plus a page-level
// reference of the store contents, driven by one directed sequence.
module tb_drum_transfer_unit;

  localparam int LL = 40;

  logic          w_CLK = 1'b0;
  logic          w_RST, w_START, w_DIR, w_BUS_GNT;
  logic [4:0]    b_TUBE_SEL;
  logic [7:0]    b_TRACK_SEL;
  logic          w_BUS_REQ, ready_out, ready_in, w_HS;
  logic [9:0]    b_MS_ADDR;
  logic [LL-1:0] b_MS_ZERO, b_MS_DATA_IN, b_MS_DATA_OUT;
  logic [7:0]    b_DRUM_TRACK;
  logic [LL-1:0] b_DRUM_WDATA, b_DRUM_RDATA;
  logic          w_DRUM_WVALID, w_DRUM_WREADY, w_DRUM_RVALID, w_DRUM_RREADY;
  logic          w_BUSY, w_DONE;

  drum_transfer_unit dut (
    .w_CLK(w_CLK), .w_RST(w_RST), .w_START(w_START), .w_DIR(w_DIR),
    .b_TUBE_SEL(b_TUBE_SEL), .b_TRACK_SEL(b_TRACK_SEL), .w_BUS_GNT(w_BUS_GNT),
    .w_BUS_REQ(w_BUS_REQ), .ready_out(ready_out), .ready_in(ready_in), .w_HS(w_HS),
    .b_MS_ADDR(b_MS_ADDR), .b_MS_ZERO(b_MS_ZERO), .b_MS_DATA_IN(b_MS_DATA_IN),
    .b_MS_DATA_OUT(b_MS_DATA_OUT), .b_DRUM_TRACK(b_DRUM_TRACK),
    .b_DRUM_WDATA(b_DRUM_WDATA), .w_DRUM_WVALID(w_DRUM_WVALID),
    .w_DRUM_WREADY(w_DRUM_WREADY), .b_DRUM_RDATA(b_DRUM_RDATA),
    .w_DRUM_RVALID(w_DRUM_RVALID), .w_DRUM_RREADY(w_DRUM_RREADY),
    .w_BUSY(w_BUSY), .w_DONE(w_DONE)
  );

  always #5 w_CLK = ~w_CLK;

  logic [LL-1:0] mem [1024];
  logic [LL-1:0] exp_mem [1024];
  logic [LL-1:0] rd_words [$];
  logic [LL-1:0] drum_got [$];
  int rd_idx, scan_cnt, beat_cnt, excl_err, gnt_err, stab_err, scan_bad, stall_seen, done_cnt;
  int gnt_mode, stall_word, stall_left, again_at;
  bit rv_rand, wr_rand, rd_pend, hold_pend;
  logic [9:0]    rd_addr;
  logic [LL-1:0] hold_val;
  int checks, passes, cyc, n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_stats();
    rd_words.delete();
    drum_got.delete();
    rd_idx = 0; scan_cnt = 0; beat_cnt = 0; excl_err = 0; gnt_err = 0;
    stab_err = 0; scan_bad = 0; stall_seen = 0; done_cnt = 0;
  endtask

  task automatic run_xfer(input bit dir, input logic [4:0] tube, input logic [7:0] track,
                          input int budget, output int cycles);
    w_DIR = dir; b_TUBE_SEL = tube; b_TRACK_SEL = track; w_START = 1'b1;
    cycles = 0;
    do begin
      @(negedge w_CLK);
      cycles++;
      if (cycles == again_at) begin
        w_START = 1'b1; w_DIR = ~dir; b_TUBE_SEL = 5'd0; b_TRACK_SEL = ~track;
      end else begin
        w_START = 1'b0;
      end
    end while (!w_DONE && cycles < budget);
    check("done_reached", w_DONE, 1'b1);
  endtask

  // Reference: a drum->store page leaves each line equal to the drum word.
  task automatic check_page(input string tag, input int tube);
    for (int i = 0; i < 32; i++) check(tag, mem[tube*32+i], exp_mem[tube*32+i]);
  endtask

  // Reference: a store->drum page yields the page words in order.
  task automatic check_drum(input string tag, input int tube);
    check({tag, "_count"}, drum_got.size(), 32);
    for (int i = 0; i < 32 && i < drum_got.size(); i++)
      check(tag, drum_got[i], exp_mem[tube*32+i]);
  endtask

  initial begin
    w_RST = 1'b1; w_START = 1'b0; w_DIR = 1'b0; b_TUBE_SEL = '0; b_TRACK_SEL = '0;
    w_BUS_GNT = 1'b0; b_MS_DATA_OUT = '0; b_DRUM_RDATA = '0;
    w_DRUM_RVALID = 1'b0; w_DRUM_WREADY = 1'b0;
    gnt_mode = 0; rv_rand = 0; wr_rand = 0; stall_word = -1; stall_left = 0; again_at = -1;
    rd_pend = 0; rd_addr = '0; hold_pend = 0; hold_val = '0;
    checks = 0; passes = 0;
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    clear_stats();

    fork
      forever begin
        @(posedge w_CLK);
        if (ready_in && !w_HS) mem[b_MS_ADDR] = (mem[b_MS_ADDR] & ~b_MS_ZERO) | b_MS_DATA_IN;
        if (ready_in && w_HS && (b_MS_DATA_IN != '0 || b_MS_ZERO != '0 || b_MS_ADDR != '0)) scan_bad++;
        rd_pend = ready_out && !w_HS;
        rd_addr = b_MS_ADDR;
        if (ready_in && w_HS) scan_cnt++;
        if (ready_in || ready_out) beat_cnt++;
        if (ready_in && ready_out) excl_err++;
        if ((ready_in || ready_out) && !w_BUS_GNT) gnt_err++;
        if (w_DRUM_RVALID && w_DRUM_RREADY) rd_idx++;
        if (w_DRUM_WVALID && w_DRUM_WREADY) drum_got.push_back(b_DRUM_WDATA);
        if (hold_pend && (!w_DRUM_WVALID || b_DRUM_WDATA !== hold_val)) stab_err++;
        hold_pend = w_DRUM_WVALID && !w_DRUM_WREADY;
        hold_val  = b_DRUM_WDATA;
        if (hold_pend) stall_seen++;
        if (w_DONE) done_cnt++;
      end
      forever begin
        @(negedge w_CLK);
        case (gnt_mode)
          0:       w_BUS_GNT = 1'b1;
          1:       w_BUS_GNT = ~w_BUS_GNT;
          default: w_BUS_GNT = 1'($urandom);
        endcase
        b_MS_DATA_OUT = rd_pend ? mem[rd_addr] : '0;
        if (rd_idx < rd_words.size()) begin
          w_DRUM_RVALID = rv_rand ? 1'($urandom) : 1'b1;
          b_DRUM_RDATA  = rd_words[rd_idx];
        end else begin
          w_DRUM_RVALID = 1'b0;
          b_DRUM_RDATA  = '0;
        end
        if (stall_left > 0 && drum_got.size() == stall_word) begin
          w_DRUM_WREADY = 1'b0;
          if (w_DRUM_WVALID) stall_left--;
        end else begin
          w_DRUM_WREADY = wr_rand ? 1'($urandom) : 1'b1;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge w_CLK);
    check("rst_ctrl", {w_BUS_REQ, ready_out, ready_in, w_HS, w_DRUM_WVALID, w_DRUM_RREADY, w_BUSY, w_DONE}, 8'h00);
    check("rst_addr", b_MS_ADDR, 10'h000);
    check("rst_zero_data", {b_MS_ZERO, b_MS_DATA_IN}, 80'h0);
    check("rst_drum", {b_DRUM_TRACK, b_DRUM_WDATA}, 48'h0);
    w_RST = 1'b0;
    @(negedge w_CLK);

    // drum->store, tube 1, word i+0x100, grant and valid held
    clear_stats();
    for (int i = 0; i < 32; i++) begin
      rd_words.push_back(40'(i + 'h100));
      exp_mem[32+i] = 40'(i + 'h100);
    end
    run_xfer(1'b0, 5'd1, 8'h5A, 400, cyc);
    check("t1_cycles", cyc, 97);
    repeat (3) @(negedge w_CLK);
    check_page("t1_line", 1);
    check("t1_scans", scan_cnt, 32);
    check("t1_beats", beat_cnt, 64);
    check("t1_done_count", done_cnt, 1);
    check("t1_track", b_DRUM_TRACK, 8'h5A);
    check("t1_idle", {w_BUSY, w_BUS_REQ}, 2'b00);

    // store->drum, tube 0 preloaded, WREADY low for 3 cycles on word 5
    clear_stats();
    for (int i = 0; i < 32; i++) begin
      mem[i] = 40'hFF_FFFF_FFFF ^ 40'(i);
      exp_mem[i] = 40'hFF_FFFF_FFFF ^ 40'(i);
    end
    stall_word = 5; stall_left = 3;
    run_xfer(1'b1, 5'd0, 8'h33, 600, cyc);
    check("t2_cycles", cyc, 132);
    repeat (3) @(negedge w_CLK);
    check_drum("t2_word", 0);
    check("t2_stall_cycles", stall_seen, 3);
    check("t2_wdata_stable", stab_err, 0);
    check("t2_scans", scan_cnt, 32);
    check("t2_store_kept", mem[5], exp_mem[5]);
    stall_word = -1;

    // store->drum with grant toggling every cycle
    clear_stats();
    gnt_mode = 1;
    run_xfer(1'b1, 5'd1, 8'h44, 1000, cyc);
    check("t3_slowed", (cyc >= 160 && cyc <= 260), 1'b1);
    repeat (3) @(negedge w_CLK);
    check_drum("t3_word", 1);
    check("t3_no_strobe_wo_grant", gnt_err, 0);
    check("t3_exclusive", excl_err, 0);
    gnt_mode = 0;

    // reset at word 10 of drum->store
    clear_stats();
    for (int i = 0; i < 32; i++) rd_words.push_back(40'(i + 'h200));
    w_DIR = 1'b0; b_TUBE_SEL = 5'd1; b_TRACK_SEL = 8'h77; w_START = 1'b1;
    @(negedge w_CLK);
    w_START = 1'b0;
    n = 0;
    while (rd_idx < 10 && n < 500) begin @(negedge w_CLK); n++; end
    check("t4_word10_reached", rd_idx, 10);
    w_RST = 1'b1;
    @(negedge w_CLK);
    w_RST = 1'b0;
    check("t4_ctrl_zero", {w_BUS_REQ, ready_out, ready_in, w_HS, w_DRUM_WVALID, w_DRUM_RREADY, w_BUSY, w_DONE}, 8'h00);
    check("t4_bus_zero", {b_MS_ADDR, b_MS_ZERO, b_MS_DATA_IN}, 90'h0);
    check("t4_track_zero", b_DRUM_TRACK, 8'h00);
    repeat (40) @(negedge w_CLK);
    check("t4_no_done", done_cnt, 0);
    check("t4_partial_line0", mem[32], 40'h200);
    check("t4_untouched_line20", mem[52], 40'h114);

    // new START completes; random data, random valid and grant
    clear_stats();
    gnt_mode = 2; rv_rand = 1;
    for (int i = 0; i < 32; i++) begin
      rd_words.push_back(40'({$urandom(), $urandom()}));
      exp_mem[32+i] = rd_words[i];
    end
    run_xfer(1'b0, 5'd1, 8'h9C, 3000, cyc);
    repeat (3) @(negedge w_CLK);
    check_page("t5_line", 1);
    check("t5_scans", scan_cnt, 32);
    check("t5_no_strobe_wo_grant", gnt_err, 0);
    check("t5_scan_clean", scan_bad, 0);
    check("t5_done_count", done_cnt, 1);
    rv_rand = 0;

    // START pulsed again while busy is ignored
    clear_stats();
    wr_rand = 1; again_at = 20;
    run_xfer(1'b1, 5'd1, 8'hC3, 3000, cyc);
    again_at = -1;
    repeat (10) @(negedge w_CLK);
    check_drum("t6_word", 1);
    check("t6_single_done", done_cnt, 1);
    check("t6_track", b_DRUM_TRACK, 8'hC3);
    check("t6_exclusive", excl_err, 0);
    check("t6_wdata_stable", stab_err, 0);
    wr_rand = 0; gnt_mode = 0;

    // tube 3 rejected: no beats, DONE one cycle after START
    clear_stats();
    rd_words.push_back(40'h123);
    run_xfer(1'b0, 5'd3, 8'h11, 10, cyc);
    check("t7_done_latency", cyc, 1);
    repeat (5) @(negedge w_CLK);
    check("t7_no_beats", beat_cnt, 0);
    check("t7_no_drum", rd_idx, 0);
    check("t7_done_count", done_cnt, 1);

    // zero mask clears an all-ones line
    clear_stats();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '1;
      exp_mem[i] = '0;
      rd_words.push_back('0);
    end
    run_xfer(1'b0, 5'd0, 8'h01, 400, cyc);
    check("t8_cycles", cyc, 97);
    repeat (3) @(negedge w_CLK);
    check_page("t8_line", 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/drum_transfer_unit.md
Name: drum_transfer_unit

Overview:
- Initiator on the main-store port. Moves one whole tube page (TUBE_DEPTH words) between a selected tube and a magnetic-drum track.
- Two directions: store->drum ("write drum") and drum->store ("read drum").
- Issues action beats (w_HS=0) and interleaved scan beats (w_HS=1) so the beam-position rotation keeps advancing while the unit owns the bus.
- Sits beside the main control sequencer; bus ownership is arbitrated by w_BUS_GNT.

Parameters:
- LINE_LENGTH, 40, bits per store line / drum word
- INSTR_ADDR_BITS, 10, store address width ([0:4] tube, [5:9] word)
- TUBE_DEPTH, 32, words per tube page
- N_TUBES, 2, tubes addressable
- TRACK_BITS, 8, drum track number width

Ports:
- w_CLK  in  1  clock
- w_RST  in  1  reset; synchronous, active-high
- w_START  in  1  one-cycle request to begin a transfer
- w_DIR  in  1  1 = store->drum, 0 = drum->store; sampled with w_START
- b_TUBE_SEL  in  5  tube number; sampled with w_START
- b_TRACK_SEL  in  TRACK_BITS  drum track; sampled with w_START
- w_BUS_GNT  in  1  store bus granted this cycle
- w_BUS_REQ  out  1  store bus requested
- ready_out  out  1  store read strobe
- ready_in  out  1  store write strobe
- w_HS  out  1  1 = scan beat, 0 = action beat
- b_MS_ADDR  out  INSTR_ADDR_BITS  {tube, word}
- b_MS_ZERO  out  LINE_LENGTH  store zero mask
- b_MS_DATA_IN  out  LINE_LENGTH  write data to store
- b_MS_DATA_OUT  in  LINE_LENGTH  store read data; valid the cycle after a ready_out action beat
- b_DRUM_TRACK  out  TRACK_BITS  latched track
- b_DRUM_WDATA  out  LINE_LENGTH  word to drum
- w_DRUM_WVALID  out  1  drum write word valid
- w_DRUM_WREADY  in  1  drum accepts word
- b_DRUM_RDATA  in  LINE_LENGTH  word from drum
- w_DRUM_RVALID  in  1  drum read word valid
- w_DRUM_RREADY  out  1  unit accepts drum word
- w_BUSY  out  1  transfer in progress
- w_DONE  out  1  one-cycle pulse at completion

Behaviour:
- Reset: state IDLE, word counter 0. All outputs 0, including strobes, w_HS, ZERO, data, valid/ready, BUSY and DONE.
- Reset mid-transfer: abandon immediately with no DONE; the partial page stays in the store/drum as is.
- Store strobe rule: ready_out, ready_in and w_BUS_REQ=1 are driven only in beat states. A beat fires only in a cycle where w_BUS_GNT=1; otherwise the state holds and the strobes stay 0.
- Exclusivity: ready_out and ready_in are never 1 together.
- State IDLE:
  - On w_START=1, latch dir/tube/track, clear the word counter, set BUSY=1.
  - Next state is RD_BEAT when dir=1, WR_WAIT when dir=0.
  - w_START while BUSY is ignored.
- store->drum path:
  - RD_BEAT: ready_out=1, w_HS=0, ADDR={tube,count}, ZERO=0 -> RD_CAPT.
  - RD_CAPT: capture b_MS_DATA_OUT into the word buffer -> DRUM_PUSH.
  - DRUM_PUSH: WVALID=1, WDATA=buffer, held stable until WREADY=1. On that handshake cycle -> SCAN.
- drum->store path:
  - WR_WAIT: RREADY=1. On RVALID=1, capture RDATA into the buffer -> WR_BEAT.
  - WR_BEAT: ready_in=1, w_HS=0, ADDR={tube,count}, ZERO=all ones, DATA_IN=buffer. The store line becomes exactly the buffer -> SCAN.
- SCAN: one scan beat per word, ready_in=1, w_HS=1, ZERO=0, DATA_IN=0, ADDR=0. Store contents are unchanged and its scan pointer advances by 1.
  - If count==TUBE_DEPTH-1 -> DONE.
  - Otherwise count+1, then return to RD_BEAT (dir=1) or WR_WAIT (dir=0).
- DONE: DONE=1 for one cycle, BUSY=0 -> IDLE. The counter wraps to 0.
- Grant loss:
  - Between beats: the unit waits in its state.
  - During DRUM_PUSH / WR_WAIT: the drum handshake proceeds regardless of grant.
- Timing: b_DRUM_TRACK holds the latched track from START until the next START.
- Latency with grant held and the drum always ready:
  - store->drum: 4 cycles per word, 128 + 1 (DONE) cycles after START.
  - drum->store: 3 cycles per word.
- Tube select at or above N_TUBES: the transfer is rejected. No beats are issued, and DONE pulses one cycle after START.

Test Plan:
- drum->store, tube 1, RDATA = word index + 0x100, grant/valid always 1 -> every tube-1 line i = i+0x100; 32 scan beats seen; DONE at cycle 97 after START.
- store->drum, tube 0 preloaded with 0xFFFFFFFFFF ^ i -> drum receives the 32 words in order, WDATA stable while WREADY is held low for 3 cycles on word 5.
- Grant toggling 1/0 every cycle during store->drum -> no strobe while grant=0, data correct, total cycles roughly doubled.
- w_RST asserted at word 10 of drum->store -> outputs 0 next cycle, no DONE; a new START then completes normally.
- w_START pulsed again while BUSY -> ignored, single DONE; START with tube 3 (N_TUBES=2) -> no beats, DONE 1 cycle later.
- drum->store into a line preloaded with all ones, RDATA=0 -> line reads 0 (ZERO mask clears the old contents).
